// File: rtl/shift_sequencer5.sv
// shift_sequencer5: drives an external 5-bit universal shift register to
// transmit a word serially (LSB or MSB first), receive a serial word, or
// rotate a word right by 0..7 positions (taken mod 5).
module shift_sequencer5 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [4:0] din,
    input  logic [2:0] rot_amt,
    input  logic       ser_in,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       busy,
    output logic       done,
    output logic [4:0] dout,
    output logic [1:0] usr_sel,
    output logic [4:0] usr_pi,
    output logic       usr_si,
    input  logic [4:0] usr_po
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] CAPT  = 2'd3;

    localparam logic [1:0] OP_TX_LSB = 2'b00;
    localparam logic [1:0] OP_TX_MSB = 2'b01;
    localparam logic [1:0] OP_RX     = 2'b10;
    localparam logic [1:0] OP_ROT    = 2'b11;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    logic [1:0] state;
    logic [2:0] cnt;
    logic [1:0] op_q;
    logic [4:0] din_q;
    logic [2:0] n_q;
    logic [2:0] n_next;

    // Shift count for a request: full word for TX/RX, rot_amt mod 5 for rotate
    always_comb begin
        n_next = 3'd5;
        if (op == OP_ROT)
            n_next = (rot_amt >= 3'd5) ? (rot_amt - 3'd5) : rot_amt;
    end

    // Sequencer state, captured request, and result/done registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            op_q  <= 2'b00;
            din_q <= 5'd0;
            n_q   <= 3'd0;
            dout  <= 5'd0;
            done  <= 1'b0;
        end else begin
            // done is high only in the first IDLE cycle after CAPT
            done <= (state == CAPT);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        din_q <= din;
                        n_q   <= n_next;
                        cnt   <= 3'd0;
                        state <= (op == OP_RX) ? SHIFT : LOAD;
                    end
                end
                LOAD: begin
                    cnt   <= 3'd0;
                    state <= (n_q == 3'd0) ? CAPT : SHIFT;
                end
                SHIFT: begin
                    if (cnt == n_q - 3'd1) begin
                        cnt   <= 3'd0;
                        state <= CAPT;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    dout  <= usr_po;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Shift-register control and serial outputs decoded from state and op
    always_comb begin
        usr_sel   = SEL_HOLD;
        usr_pi    = 5'd0;
        usr_si    = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            LOAD: begin
                usr_sel = SEL_LOAD;
                usr_pi  = din_q;
            end
            SHIFT: begin
                case (op_q)
                    OP_TX_LSB: begin
                        usr_sel   = SEL_RIGHT;
                        ser_out   = usr_po[0];
                        ser_valid = 1'b1;
                    end
                    OP_TX_MSB: begin
                        usr_sel   = SEL_LEFT;
                        ser_out   = usr_po[4];
                        ser_valid = 1'b1;
                    end
                    OP_RX: begin
                        usr_sel = SEL_RIGHT;
                        usr_si  = ser_in;
                    end
                    default: begin
                        usr_sel = SEL_RIGHT;
                        usr_si  = usr_po[0];
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: doc/shift_sequencer5.md
SHIFT_SEQUENCER5 -- requirements
Module: shift_sequencer5

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low; sampled on rising clk.
REQ-003 start  input  1  operation request; accepted only when busy=0.
REQ-004 op  input  2  operation: 00 TX_LSB, 01 TX_MSB, 10 RX, 11 ROTATE.
REQ-005 din  input  5  parallel word for TX_LSB/TX_MSB/ROTATE; captured with start.
REQ-006 rot_amt  input  3  ROTATE right amount; captured with start.
REQ-007 ser_in  input  1  serial receive bit for RX.
REQ-008 ser_out  output  1  serial transmit bit.
REQ-009 ser_valid  output  1  high while ser_out carries a TX bit.
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 dout  output  5  register word captured at operation end.
REQ-013 usr_sel  output  2  shift-register mode: 00 hold, 01 shift right (SI->bit4, bit0 out), 10 shift left (SI->bit0, bit4 out), 11 parallel load.
REQ-014 usr_pi  output  5  shift-register parallel input.
REQ-015 usr_si  output  1  shift-register serial input.
REQ-016 usr_po  input  5  shift-register parallel output.

Function
REQ-017 States SHALL be IDLE, LOAD, SHIFT, CAPT; 3-bit shift counter; captured op_q, din_q, n_q.
REQ-018 IDLE with start=1 SHALL capture op, din, rot_amt; next state LOAD (op!=RX) or SHIFT (RX).
REQ-019 start while busy=1 SHALL be ignored with no effect on state or captured values.
REQ-020 Shift count n_q SHALL be 5 for TX_LSB/TX_MSB/RX, rot_amt mod 5 for ROTATE (5->0, 6->1, 7->2).
REQ-021 LOAD (1 cycle): usr_sel=11, usr_pi=din_q; next SHIFT, or CAPT if n_q=0.
REQ-022 SHIFT (n_q cycles): usr_sel=01 for TX_LSB/RX/ROTATE, 10 for TX_MSB; after n_q cycles next CAPT.
REQ-023 usr_si in SHIFT SHALL be 0 (TX_LSB/TX_MSB), ser_in combinationally (RX), usr_po[0] (ROTATE); 0 in all other states.
REQ-024 ser_out SHALL be usr_po[0] (TX_LSB SHIFT), usr_po[4] (TX_MSB SHIFT), else 0; ser_valid=1 exactly in TX SHIFT cycles.
REQ-025 CAPT (1 cycle): usr_sel=00; at its closing edge dout<=usr_po, done<=1, state<=IDLE.
REQ-026 usr_sel SHALL be 00 and usr_pi SHALL be 00000 in IDLE and CAPT.
REQ-027 busy SHALL be 1 in LOAD, SHIFT, CAPT; 0 in IDLE, including the done cycle.
REQ-028 done SHALL be high exactly one cycle, the first IDLE cycle after CAPT; dout holds until next CAPT.
REQ-029 start sampled in the done cycle SHALL be accepted (back-to-back, no idle gap).
REQ-030 Latency from accepting edge: TX done at cycle 8; RX done at cycle 7; ROTATE done at cycle n_q+3.

Reset
REQ-031 rst=0 at any edge SHALL force IDLE, counter 0, busy=0, done=0, dout=00000, op_q/din_q/n_q=0, aborting any operation.
REQ-032 After reset, usr_sel=00, usr_pi=00000, usr_si=0, ser_out=0, ser_valid=0; shift-register contents unaffected by this block.
REQ-033 First start accepted at first edge with rst=1.

Verification (bench instantiates 5-bit universal shift register with REQ-013 encoding)
REQ-034 TX_LSB din=10101 -> ser_out 1,0,1,0,1 with ser_valid cycles 2-6; done cycle 8; dout=00000.
REQ-035 TX_MSB din=10011 -> ser_out 1,0,0,1,1; done cycle 8; dout=00000.
REQ-036 RX ser_in 1,1,0,0,1 over cycles 1-5 -> done cycle 7, dout=10011.
REQ-037 ROTATE din=00001: rot_amt=2 -> dout=01000 at cycle 5; rot_amt=7 -> dout=01000; rot_amt=0 -> dout=00001, done cycle 3.
REQ-038 start pulsed during SHIFT -> ignored, result unchanged; start in done cycle -> new op begins, busy=1 next cycle.
REQ-039 rst=0 during TX_LSB SHIFT cycle 4 -> next cycle busy=0, done=0, dout=00000, usr_sel=00, ser_valid=0, no done pulse.
